fsm_check_seq: RTL and testbench
================================

# fsm_check_seq

Self-checking step sequencer for the 2/4/5/6/7 state machine implementations (case-based, gate-level, ROM-based). It resets the attached machine, drives its `a` input one bit per step from a captured pattern, and gates its clock enable. After each step it compares the returned state against an internal golden transition model, counting mismatches. It sits between a test/host controller and one state machine instance, so all three implementations can be qualified by the same block.

## Interface
- `PAT_W`, 16: pattern register width, which is also the maximum number of steps.
- `CNT_W`, 5: width of `len`, `err_count` and `err_step`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: run request, sampled in IDLE only.
- `pattern` in PAT_W: `a` bit sequence, bit 0 applied first, captured on start.
- `len` in CNT_W: number of steps, captured on start, clamped to PAT_W.
- `dut_state` in 3: current state from the machine under test.
- `dut_a` out 1: `a` input to the machine.
- `dut_en` out 1: step enable to the machine; one step per high cycle.
- `dut_res_n` out 1: active-low reset to the machine.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle end-of-run pulse.
- `pass` out 1: last run had zero mismatches.
- `err_count` out CNT_W: mismatches in the last run; saturates at 2^CNT_W-1.
- `err_step` out CNT_W: check index of the first mismatch.

## Operation
- FSM states: IDLE, INIT, CHK, STEP, FIN.
- All outputs except `dut_res_n` are decoded from the state register.
- `dut_res_n` is a flop with reset value 0. It loads 0 when entering INIT and 1 otherwise.
- IDLE → INIT when `start`=1. On this transition:
  - capture `pattern`, and capture `len` as min(`len`, PAT_W);
  - clear `err_count`, `err_step` and the step index `idx`.
- INIT:
  - `dut_res_n`=0 and golden state g<=2;
  - next state is CHK.
- CHK compares `dut_state` with g.
  - On mismatch: increment `err_count`; if this is the first mismatch, `err_step`<=`idx`.
  - If `idx`==len, go to FIN; otherwise go to STEP.
- STEP:
  - drive `dut_en`=1 and `dut_a`=pattern[idx];
  - g<=next(g, pattern[idx]) and `idx`<=`idx`+1;
  - next state is CHK.
- Golden transitions:
  - 2→6, 7→5, 5→4;
  - 4→6 if a, else 2;
  - 6→7 if a, else 5;
  - undefined codes 0, 1, 3 hold their value.
- FIN:
  - `done`=1 and `pass`<=(`err_count`==0);
  - next state is IDLE.
- `busy`=1 in INIT, CHK and STEP.
- `start` outside IDLE is ignored. Pattern and length changes during a run are ignored.

## Timing
- Reset values:
  - state IDLE;
  - `dut_res_n`=0, `dut_en`=0, `dut_a`=0;
  - `busy`=0, `done`=0, `pass`=0, `err_count`=0, `err_step`=0.
- `dut_res_n` returns to 1 at the first clk edge after reset deasserts.
- Cycle 0 is the edge where `start` is sampled. Then:
  - INIT is cycle 1;
  - the initial CHK is cycle 2;
  - step k occupies STEP at cycle 2k+1 and CHK at cycle 2k+2;
  - FIN (`done`) is at cycle 2N+3, with N the clamped length.
- The machine advances on the clk edge that ends a STEP cycle. `dut_state` must be valid during the following CHK cycle, with no extra pipeline stage.
- `pass`, `err_count` and `err_step` hold until the next run starts.
- Reset mid-run forces the reset values immediately, with no `done` pulse. The machine is held in reset because `dut_res_n`=0.
- len=0: only the initial check runs, and `done` is at cycle 3.

## Configuration
- `FSM_CHECK_STOP_ON_ERR_EN` defined: the first mismatch in CHK goes directly to FIN, so `err_count`=1 in a failing run. `done` is then at cycle 2k+3 for a mismatch at check k.
- Undefined: every step runs to len regardless of mismatches.

## Test plan
- Case-based machine attached, pattern=0, len=4: states checked are 2,6,5,4,2 → `done` at cycle 11, `pass`=1, `err_count`=0.
- pattern=16'hFFFF, len=5: states checked are 2,6,7,5,4,6 → `pass`=1, `done` at cycle 13.
- `dut_state` stuck at 6, pattern=0, len=3 → `err_count`=3, `err_step`=0, `pass`=0. With `FSM_CHECK_STOP_ON_ERR_EN` defined: `err_count`=1 and `done` at cycle 3.
- `reset` pulled low during the 3rd STEP → next cycle shows `busy`=0, `dut_res_n`=0, `err_count`=0, no `done`. A new start after release with pattern=0, len=4 passes.
- len=20 with PAT_W=16 → run clamps to 16 steps, `done` at cycle 35. A `start` pulse at cycle 10 has no effect.
- len=0, correct machine → `done` at cycle 3, `pass`=1, `dut_en` never asserted.

Source files
------------

// File: rtl/fsm_check_seq.sv
// fsm_check_seq: step sequencer that qualifies an attached 2/4/5/6/7 state
// machine against a built-in golden transition model.
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   start            run request, sampled in IDLE only
//   pattern, len     'a' bit sequence (bit 0 first) and step count, captured
//                    on start; len is clamped to PAT_W
//   dut_state        current state returned by the machine under test
//   dut_a, dut_en    'a' input and one-step-per-cycle enable to the machine
//   dut_res_n        active-low reset to the machine (flop, resets to 0)
//   busy, done       run in progress / one-cycle end-of-run pulse
//   pass             last run had zero mismatches
//   err_count        mismatches in the last run (saturating)
//   err_step         check index of the first mismatch
//
// Build option: define FSM_CHECK_STOP_ON_ERR_EN to end a run at the first
// mismatch; left undefined, every run executes all len steps.
module fsm_check_seq #(
  parameter int unsigned PAT_W = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] len,
  input  logic [2:0]       dut_state,
  output logic             dut_a,
  output logic             dut_en,
  output logic             dut_res_n,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] err_step
);

  localparam int unsigned      IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [2:0]       G_INIT  = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CHK,
    S_STEP,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] idx_q;
  logic [2:0]       g_q;
  logic             cur_a_c;
  logic             mismatch_c;

  // Golden transition model; unused codes hold.
  function automatic logic [2:0] gold_next(input logic [2:0] s, input logic a);
    logic [2:0] n;
    n = s;
    case (s)
      3'd2:    n = 3'd6;
      3'd7:    n = 3'd5;
      3'd5:    n = 3'd4;
      3'd4:    n = a ? 3'd6 : 3'd2;
      3'd6:    n = a ? 3'd7 : 3'd5;
      default: n = s;
    endcase
    return n;
  endfunction

  assign cur_a_c    = pat_q[idx_q[IDX_W-1:0]];
  assign mismatch_c = (dut_state != g_q);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    dut_en  = 1'b0;
    dut_a   = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: begin
        busy    = 1'b1;
        state_d = S_CHK;
      end
      S_CHK: begin
        busy = 1'b1;
`ifdef FSM_CHECK_STOP_ON_ERR_EN
        if (mismatch_c || idx_q == len_q) state_d = S_FIN;
        else                              state_d = S_STEP;
`else
        if (idx_q == len_q) state_d = S_FIN;
        else                state_d = S_STEP;
`endif
      end
      S_STEP: begin
        busy    = 1'b1;
        dut_en  = 1'b1;
        dut_a   = cur_a_c;
        state_d = S_CHK;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Run capture, golden model, error bookkeeping and machine reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dut_res_n <= 1'b0;
      pat_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      g_q       <= '0;
      pass      <= 1'b0;
      err_count <= '0;
      err_step  <= '0;
    end else begin
      // Machine is held in reset for exactly the INIT cycle.
      dut_res_n <= (state_d != S_INIT);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pat_q     <= pattern;
            len_q     <= (len > LEN_MAX) ? LEN_MAX : len;
            idx_q     <= '0;
            err_count <= '0;
            err_step  <= '0;
          end
        end
        S_INIT: g_q <= G_INIT;
        S_CHK: begin
          if (mismatch_c) begin
            if (err_count != CNT_SAT) err_count <= err_count + CNT_W'(1);
            if (err_count == '0)      err_step  <= idx_q;
          end
        end
        S_STEP: begin
          g_q   <= gold_next(g_q, cur_a_c);
          idx_q <= idx_q + CNT_W'(1);
        end
        S_FIN: pass <= (err_count == '0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_check_seq.sv
// Directed bench for fsm_check_seq with a behavioural 2/4/5/6/7 machine
// attached, optionally forced to a stuck state to provoke mismatches.
module tb_fsm_check_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [2:0]  dut_state;
  logic        dut_a, dut_en, dut_res_n, busy, done, pass;
  logic [4:0]  err_count, err_step;

  int checks = 0;
  int failures = 0;

  // Attached machine model
  logic [2:0] m_state;
  logic       stuck_en = 1'b0;
  logic [2:0] stuck_val = 3'd0;

  always #5 clk = ~clk;

  fsm_check_seq #(.PAT_W(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .dut_state(dut_state), .dut_a(dut_a), .dut_en(dut_en),
    .dut_res_n(dut_res_n), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .err_step(err_step)
  );

  function automatic logic [2:0] mach_next(input logic [2:0] s, input logic a);
    case (s)
      3'd2:    return 3'd6;
      3'd6:    return a ? 3'd7 : 3'd5;
      3'd7:    return 3'd5;
      3'd5:    return 3'd4;
      3'd4:    return a ? 3'd6 : 3'd2;
      default: return s;
    endcase
  endfunction

  always_ff @(posedge clk or negedge dut_res_n) begin
    if (!dut_res_n)  m_state <= 3'd2;
    else if (dut_en) m_state <= mach_next(m_state, dut_a);
  end

  assign dut_state = stuck_en ? stuck_val : m_state;

  // Launch one run and watch it; cycle 1 is the first cycle after the start edge.
  task automatic run_seq(input logic [15:0] pat, input logic [4:0] n,
                         input int start_at, output int done_cyc,
                         output int en_cnt, output int a_bad, output int busy_low);
    int k;
    done_cyc = -1; en_cnt = 0; a_bad = 0; busy_low = 0; k = 0;
    @(negedge clk);
    pattern = pat; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!busy) busy_low++;
      if (dut_en) begin
        if (dut_a !== pat[k[3:0]]) a_bad++;
        en_cnt++;
        k++;
      end
      // garbage on inputs mid-run must not matter
      pattern = ~pat;
      len = 5'd1;
      start = (cyc + 1 == start_at);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);  // first IDLE cycle: pass now updated
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; pattern = '0; len = '0;
    #12;
    checks++;
    if ({busy, done, pass, dut_en, dut_a, dut_res_n} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got busy=%b done=%b pass=%b en=%b a=%b res_n=%b, want all 0",
               busy, done, pass, dut_en, dut_a, dut_res_n);
    end
    checks++;
    if (err_count !== 5'd0 || err_step !== 5'd0) begin
      failures++;
      $display("FAIL reset_counts: got err_count=%0d err_step=%0d, want 0 0", err_count, err_step);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_res_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_res_n: got %b want 1", dut_res_n);
    end
  endtask

  task automatic test_zero_pattern;
    int dc, en, ab, bl;
    stuck_en = 1'b0;
    run_seq(16'h0000, 5'd4, 0, dc, en, ab, bl);
    checks++;
    if (dc !== 11 || en !== 4) begin
      failures++;
      $display("FAIL zero_timing: got done_cyc=%0d en=%0d, want 11 4", dc, en);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 5'd0 || ab !== 0 || bl !== 0) begin
      failures++;
      $display("FAIL zero_result: got pass=%b err=%0d a_bad=%0d busy_low=%0d, want 1 0 0 0",
               pass, err_count, ab, bl);
    end
  endtask

  task automatic test_ones_pattern;
    int dc, en, ab, bl;
    run_seq(16'hFFFF, 5'd5, 0, dc, en, ab, bl);
    checks++;
    if (dc !== 13 || pass !== 1'b1 || err_count !== 5'd0 || ab !== 0) begin
      failures++;
      $display("FAIL ones: got done_cyc=%0d pass=%b err=%0d a_bad=%0d, want 13 1 0 0",
               dc, pass, err_count, ab);
    end
  endtask

  task automatic test_mismatch;
    int dc, en, ab, bl;
    int exp_dc, exp_cnt;
    // stuck at 6: golden 2,6,5,4 -> mismatches at checks 0,2,3
    stuck_en = 1'b1; stuck_val = 3'd6;
    run_seq(16'h0000, 5'd3, 0, dc, en, ab, bl);
`ifdef FSM_CHECK_STOP_ON_ERR_EN
    exp_dc = 3; exp_cnt = 1;
`else
    exp_dc = 9; exp_cnt = 3;
`endif
    checks++;
    if (dc !== exp_dc || err_count !== 5'(exp_cnt) || err_step !== 5'd0 || pass !== 1'b0) begin
      failures++;
      $display("FAIL stuck6: got done_cyc=%0d err=%0d step=%0d pass=%b, want %0d %0d 0 0",
               dc, err_count, err_step, pass, exp_dc, exp_cnt);
    end
    // stuck at 2: golden 2,6,5,4,2 -> mismatches at checks 1,2,3
    stuck_val = 3'd2;
    run_seq(16'h0000, 5'd4, 0, dc, en, ab, bl);
`ifdef FSM_CHECK_STOP_ON_ERR_EN
    exp_dc = 5; exp_cnt = 1;
`else
    exp_dc = 11; exp_cnt = 3;
`endif
    checks++;
    if (dc !== exp_dc || err_count !== 5'(exp_cnt) || err_step !== 5'd1 || pass !== 1'b0) begin
      failures++;
      $display("FAIL stuck2: got done_cyc=%0d err=%0d step=%0d pass=%b, want %0d %0d 1 0",
               dc, err_count, err_step, pass, exp_dc, exp_cnt);
    end
    stuck_en = 1'b0;
    // results hold while idle
    repeat (4) @(negedge clk);
    checks++;
    if (err_count !== 5'(exp_cnt) || err_step !== 5'd1 || pass !== 1'b0) begin
      failures++;
      $display("FAIL hold: got err=%0d step=%0d pass=%b, want %0d 1 0",
               err_count, err_step, pass, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_run;
    int dc, en, ab, bl;
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    pattern = 16'h0000; len = 5'd4; start = 1'b1;
    @(negedge clk);   // cycle 1
    start = 1'b0;
    repeat (6) begin  // advance to cycle 7, the third STEP
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (dut_en !== 1'b1) begin
      failures++;
      $display("FAIL midrun_step3: got dut_en=%b want 1", dut_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || dut_res_n !== 1'b0 || err_count !== 5'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset_now: got busy=%b res_n=%b err=%0d done=%b, want 0 0 0 0",
               busy, dut_res_n, err_count, done);
    end
    @(negedge clk);
    if (done) saw_done = 1'b1;
    checks++;
    if (busy !== 1'b0 || dut_res_n !== 1'b0 || saw_done) begin
      failures++;
      $display("FAIL midrun_reset_next: got busy=%b res_n=%b saw_done=%b, want 0 0 0",
               busy, dut_res_n, saw_done);
    end
    reset = 1'b1;
    @(negedge clk);
    run_seq(16'h0000, 5'd4, 0, dc, en, ab, bl);
    checks++;
    if (dc !== 11 || pass !== 1'b1 || err_count !== 5'd0) begin
      failures++;
      $display("FAIL midrun_rerun: got done_cyc=%0d pass=%b err=%0d, want 11 1 0",
               dc, pass, err_count);
    end
  endtask

  task automatic test_clamp;
    int dc, en, ab, bl;
    run_seq(16'hA5C3, 5'd20, 10, dc, en, ab, bl);
    checks++;
    if (dc !== 35 || en !== 16 || ab !== 0) begin
      failures++;
      $display("FAIL clamp_timing: got done_cyc=%0d en=%0d a_bad=%0d, want 35 16 0", dc, en, ab);
    end
    checks++;
    if (pass !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clamp_result: got pass=%b busy=%b, want 1 0", pass, busy);
    end
  endtask

  task automatic test_len_zero;
    int dc, en, ab, bl;
    run_seq(16'h1234, 5'd0, 0, dc, en, ab, bl);
    checks++;
    if (dc !== 3 || en !== 0 || pass !== 1'b1) begin
      failures++;
      $display("FAIL len0: got done_cyc=%0d en=%0d pass=%b, want 3 0 1", dc, en, pass);
    end
  endtask

  task automatic test_back_to_back;
    int dc, en, ab, bl;
    // pattern 0b0110: 2,6,5(a=1? no) ... hand trace: a=0:2->6, a=1:6->7, a=1:7->5, a=0:5->4
    run_seq(16'h0006, 5'd4, 0, dc, en, ab, bl);
    checks++;
    if (dc !== 11 || pass !== 1'b1 || ab !== 0) begin
      failures++;
      $display("FAIL b2b_first: got done_cyc=%0d pass=%b a_bad=%0d, want 11 1 0", dc, pass, ab);
    end
    run_seq(16'h0155, 5'd9, 0, dc, en, ab, bl);
    checks++;
    if (dc !== 21 || en !== 9 || pass !== 1'b1 || err_count !== 5'd0) begin
      failures++;
      $display("FAIL b2b_second: got done_cyc=%0d en=%0d pass=%b err=%0d, want 21 9 1 0",
               dc, en, pass, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_zero_pattern();
    test_ones_pattern();
    test_mismatch();
    test_reset_mid_run();
    test_clamp();
    test_len_zero();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
